// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: command valid/ready channel between host and sequencer
interface counter_seq_ctrl_if #(parameter int WIDTH = 8);
    logic             cmd_valid_in;
    logic             cmd_ready_out;
    logic [1:0]       cmd_op_in;
    logic [WIDTH-1:0] cmd_arg_in;
    modport master (output cmd_valid_in, cmd_op_in, cmd_arg_in, input cmd_ready_out);
    modport slave (input cmd_valid_in, cmd_op_in, cmd_arg_in, output cmd_ready_out);
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command sequencer driving the up/down counter control inputs
module counter_seq_ctrl #(parameter int WIDTH = 8) (
    input  logic             clk_in,
    input  logic             rst_in,
    counter_seq_ctrl_if.slave cmd,
    input  logic             abort_in,
    input  logic             ovf_in,
    output logic             en_ctrl_out,
    output logic             set_ctrl_out,
    output logic             up_ctrl_out,
    output logic [WIDTH-1:0] counter_val_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             aborted_out,
    output logic             ovf_flag_out
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_NOP = 2'b11;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] steps_q, steps_d, arg_q, arg_d;
    logic [1:0]       op_q, op_d;
    logic             aborted_q, aborted_d, ovf_q, ovf_d, up_q, up_d, accept;
    assign cmd.cmd_ready_out = (state_q == IDLE) & rst_in;
    // next-state and register updates; RUN direction is remembered so it holds outside RUN
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        op_d      = op_q;
        arg_d     = arg_q;
        aborted_d = aborted_q;
        ovf_d     = ovf_q;
        up_d      = (state_q == RUN) ? (op_q == OP_UP) : up_q;
        accept    = cmd.cmd_valid_in & cmd.cmd_ready_out;
        case (state_q)
            IDLE: if (accept) begin
                op_d      = cmd.cmd_op_in;
                arg_d     = cmd.cmd_arg_in;
                steps_d   = cmd.cmd_arg_in;
                aborted_d = 1'b0;
                ovf_d     = 1'b0;
                state_d   = (cmd.cmd_op_in == OP_LOAD) ? LOAD :
                            (cmd.cmd_op_in == OP_NOP || cmd.cmd_arg_in == '0) ? DONE : RUN;
            end
            LOAD: begin
                aborted_d = abort_in;
                state_d   = DONE;
            end
            RUN: begin
                steps_d   = steps_q - WIDTH'(1);
                ovf_d     = ovf_q | ovf_in;
                aborted_d = abort_in;
                state_d   = (abort_in || steps_q == WIDTH'(1)) ? DONE : RUN;
            end
            default: begin
                ovf_d   = ovf_q | ovf_in;
                state_d = IDLE;
            end
        endcase
    end
    // Moore decode of counter controls; abort only gates the enable
    always_comb begin
        en_ctrl_out     = (state_q == RUN) & ~abort_in;
        set_ctrl_out    = state_q == LOAD;
        up_ctrl_out     = up_d;
        counter_val_out = arg_q;
        busy_out        = (state_q == LOAD) | (state_q == RUN);
        done_out        = state_q == DONE;
        aborted_out     = aborted_q;
        ovf_flag_out    = ovf_q;
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            steps_q   <= '0;
            op_q      <= '0;
            arg_q     <= '0;
            aborted_q <= 1'b0;
            ovf_q     <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            steps_q   <= steps_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            aborted_q <= aborted_d;
            ovf_q     <= ovf_d;
            up_q      <= up_d;
        end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed and random command sequences against a counter model
module tb_counter_seq_ctrl;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_NOP = 2'b11;
    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       ovf_in;
    logic       en_ctrl_out, set_ctrl_out, up_ctrl_out, busy_out, done_out, aborted_out, ovf_flag_out;
    logic [7:0] counter_val_out;
    logic [7:0] cnt = 8'h00;
    logic       c_ovf = 1'b0;
    logic [7:0] ref_cnt = 8'h00;
    int         tests = 0;
    int         fails = 0;

    counter_seq_ctrl_if #(.WIDTH(8)) cif();

    counter_seq_ctrl #(.WIDTH(8)) dut (
        .clk_in(clk), .rst_in(rst_in), .cmd(cif), .abort_in(abort_in), .ovf_in(ovf_in),
        .en_ctrl_out(en_ctrl_out), .set_ctrl_out(set_ctrl_out), .up_ctrl_out(up_ctrl_out),
        .counter_val_out(counter_val_out), .busy_out(busy_out), .done_out(done_out),
        .aborted_out(aborted_out), .ovf_flag_out(ovf_flag_out)
    );

    always #5 clk = ~clk;

    // counter datapath stand-in: flags the cycle after a count lands on its terminal value
    always @(posedge clk) begin
        if (set_ctrl_out) cnt <= counter_val_out;
        else if (en_ctrl_out) cnt <= up_ctrl_out ? cnt + 8'd1 : cnt - 8'd1;
        c_ovf <= en_ctrl_out && (up_ctrl_out ? cnt == 8'hFE : cnt == 8'h01);
    end
    assign ovf_in = c_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one command; k = en cycles before abort is raised (-1: never)
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input int k);
        int t, n_en, n_set, n_both, n_up_bad, done_t, exp_p, exp_done_t, d, w;
        logic ab_seen, exp_ab, exp_ovf;
        logic [7:0] val_seen;
        exp_ab = 1'b0; exp_ovf = 1'b0; exp_p = 0;
        if (op == OP_LOAD) begin
            exp_done_t = 2;
            exp_ab = (k == 0);
        end else if (op != OP_NOP && arg != 0) begin
            exp_ab = (k >= 0 && k < int'(arg));
            exp_p = exp_ab ? k : int'(arg);
            exp_done_t = exp_ab ? exp_p + 2 : exp_p + 1;
            d = (op == OP_UP) ? 255 - int'(ref_cnt) : int'(ref_cnt);
            exp_ovf = (d >= 1 && d <= exp_p);
        end else exp_done_t = 1;
        @(negedge clk);
        cif.cmd_valid_in = 1'b1; cif.cmd_op_in = op; cif.cmd_arg_in = arg;
        #1;
        w = 0;
        while (!cif.cmd_ready_out && w < 20) begin @(negedge clk); #1; w++; end
        check("ready_pre", cif.cmd_ready_out, 1);
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid_in = 1'b0;
        t = 1; n_en = 0; n_set = 0; n_both = 0; n_up_bad = 0; done_t = 0; ab_seen = 1'bx; val_seen = 8'hxx;
        while (done_t == 0 && t < 300) begin
            abort_in = (k >= 0 && n_en == k && busy_out);
            #1;
            if (en_ctrl_out) begin
                n_en++;
                if (up_ctrl_out !== (op == OP_UP)) n_up_bad++;
            end
            if (set_ctrl_out) begin n_set++; val_seen = counter_val_out; end
            if (en_ctrl_out && set_ctrl_out) n_both++;
            if (done_out) begin done_t = t; ab_seen = aborted_out; end
            else begin @(negedge clk); t++; end
        end
        abort_in = 1'b0;
        if (op == OP_LOAD) ref_cnt = arg;
        else if (op == OP_UP) ref_cnt = ref_cnt + 8'(exp_p);
        else if (op == OP_DOWN) ref_cnt = ref_cnt - 8'(exp_p);
        check("done_time", done_t, exp_done_t);
        check("en_count", n_en, exp_p);
        check("set_count", n_set, (op == OP_LOAD) ? 1 : 0);
        check("en_set_overlap", n_both, 0);
        check("up_dir", n_up_bad, 0);
        check("aborted", ab_seen, exp_ab);
        if (op == OP_LOAD) check("load_val", val_seen, arg);
        @(negedge clk);
        #1;
        check("counter", cnt, ref_cnt);
        check("ovf_flag", ovf_flag_out, exp_ovf);
        check("ready_post", cif.cmd_ready_out, 1);
        check("busy_post", busy_out, 0);
    endtask

    initial begin
        int op_r, k;
        logic [7:0] a;
        cif.cmd_valid_in = 1'b0; cif.cmd_op_in = 2'b00; cif.cmd_arg_in = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", cif.cmd_ready_out, 0);
        check("rst_en", en_ctrl_out, 0);
        check("rst_set", set_ctrl_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_flags", {aborted_out, ovf_flag_out, up_ctrl_out}, 0);
        check("rst_val", counter_val_out, 0);
        rst_in = 1'b1;
        #1;
        check("rst_release_ready", cif.cmd_ready_out, 1);
        // reset in the middle of UP N=10
        @(negedge clk);
        cif.cmd_valid_in = 1'b1; cif.cmd_op_in = OP_UP; cif.cmd_arg_in = 8'd10;
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid_in = 1'b0;
        #1;
        check("midrun_en", en_ctrl_out, 1);
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        #1;
        check("midrun_rst_en", en_ctrl_out, 0);
        check("midrun_rst_busy", busy_out, 0);
        check("midrun_rst_ready", cif.cmd_ready_out, 0);
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        check("midrun_ready", cif.cmd_ready_out, 1);
        // directed scenarios
        run_cmd(OP_LOAD, 8'hF0, -1);
        run_cmd(OP_UP, 8'd15, -1);
        run_cmd(OP_LOAD, 8'h05, -1);
        run_cmd(OP_DOWN, 8'd3, -1);
        check("down_up_ctrl", up_ctrl_out, 0);
        run_cmd(OP_UP, 8'd20, 4);
        run_cmd(OP_LOAD, 8'h33, 0);
        run_cmd(OP_DOWN, 8'd5, 0);
        run_cmd(OP_UP, 8'd0, -1);
        run_cmd(OP_NOP, 8'h7E, -1);
        run_cmd(OP_LOAD, 8'h00, -1);
        run_cmd(OP_DOWN, 8'd2, -1);
        // NOP held valid across DONE: second accept only in the following IDLE
        @(negedge clk);
        cif.cmd_valid_in = 1'b1; cif.cmd_op_in = OP_NOP; cif.cmd_arg_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_done1", done_out, 1);
        check("b2b_ready_in_done", cif.cmd_ready_out, 0);
        @(negedge clk);
        #1;
        check("b2b_idle_done", done_out, 0);
        check("b2b_idle_ready", cif.cmd_ready_out, 1);
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid_in = 1'b0;
        #1;
        check("b2b_done2", done_out, 1);
        // random commands
        for (int i = 0; i < 40; i++) begin
            op_r = $urandom_range(0, 3);
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 22)) : -1;
            if (op_r == 0) k = ($urandom_range(0, 1) == 0) ? 0 : -1;
            run_cmd(2'(op_r), a, k);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
